producto_bcd_conv: RTL and testbench
====================================

// Module: producto_bcd_conv
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double dabble) that sits directly downstream of the
//  sequential multiplier. On a start pulse it captures the multiplier's 2*DW-bit product, converts it
//  over 2*DW shift cycles, then presents packed BCD digits plus a significant-digit count for display logic.
//  Its start is driven by the multiplier's ready; its product input is the multiplier's final product.
// PARAMETERS
//  DW      8              operand width of the upstream multiplier
//  PW      2*DW           binary input width (product width)
//  DIGITS  5              BCD digits produced; must satisfy 10**DIGITS > 2**PW (elaboration-time check)
// PORTS
//  clk        in   1            single clock; all state on rising edge
//  rst        in   1            asynchronous, active-low reset
//  start      in   1            conversion request; sampled only while busy=0
//  product    in   PW           unsigned binary value; captured on the edge that accepts start
//  busy       out  1            high from the edge after start acceptance until return to IDLE
//  done       out  1            one-cycle pulse: bcd/sig_digits updated this cycle
//  bcd        out  4*DIGITS     packed BCD, digit 0 in bits [3:0]; holds last result until next done
//  sig_digits out  $clog2(DIGITS+1)  count of significant digits (1..DIGITS; value 0 reports 1)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, busy=0, done=0, bcd=0, sig_digits=1, all internal registers cleared.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : start=1 -> load bin_sh<=product, scratch<=0, cnt<=0; go to SHIFT. start=0 -> stay.
//   SHIFT: each cycle apply add-3 to every scratch digit >=5, then shift {scratch,bin_sh} left by 1;
//          cnt++. When cnt==PW-1 on this edge, go to DONE (exactly PW SHIFT cycles).
//   DONE : bcd<=scratch, sig_digits<=index of highest nonzero digit+1 (min 1), done=1; go to IDLE.
//  Latency: start sampled at edge E -> done high after edge E+PW+1 (E+17 for DW=8), for one cycle.
//  busy = (state != IDLE); done is registered and high only in DONE.
//  start while busy (SHIFT or DONE) is ignored; no queuing. Next start accepted in the first IDLE cycle.
//  product may change freely after the accepting edge; only the captured copy is used.
//  Add-3 adjust is applied before the shift in the same cycle; no digit ever exceeds 9 after a shift.
//  bcd and sig_digits change only on the DONE edge; they are stable otherwise (including during SHIFT).
//  Reset mid-conversion: immediate abort, all outputs to reset values, no done pulse emitted.
//  Input 0 -> bcd=0, sig_digits=1. Max input 2**PW-1 must convert without overflow of DIGITS.
// STRUCTURE
//  Package producto_bcd_pkg: state enum typedef (IDLE/SHIFT/DONE), default DW/PW/DIGITS localparams,
//   function for minimum digit count used by the elaboration check.
//  Sub-module bcd_digit_adj: 4-bit combinational add-3-if->=5; instantiated DIGITS times via generate.
//  Top holds FSM, shift counter ($clog2(PW) bits), bin_sh, scratch, output registers.
// TESTING
//  1 product=16'h0000, start pulse -> done after 17 edges, bcd=20'h00000, sig_digits=1.
//  2 product=16'd10795 (8'h55*8'h7F) -> bcd=20'h10795, sig_digits=5; busy high 17 cycles.
//  3 product=16'd7225 (8'h55*8'h55) -> bcd=20'h07225, sig_digits=4.
//  4 product=16'hFFFF -> bcd=20'h65535, sig_digits=5; no digit >9 observed in scratch at any cycle.
//  5 start again 5 cycles into conversion with different product -> ignored; result of first product only,
//    single done pulse; then start in first IDLE cycle accepted (back-to-back, 1-cycle gap).
//  6 rst low at SHIFT cycle 8 -> busy=0, done=0, bcd=0 immediately; no done pulse; restart converts correctly.

Source files
------------

// File: rtl/producto_bcd_pkg.sv
// Shared types and defaults for the product-to-BCD converter.
package producto_bcd_pkg;

    localparam int DEF_DW     = 8;
    localparam int DEF_PW     = 2 * DEF_DW;
    localparam int DEF_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Smallest digit count d with 10**d > 2**pw, so the largest input never overflows.
    function automatic int min_digits(input int pw);
        longint lim;
        longint pow10;
        int     d;
        lim   = longint'(1) << pw;
        pow10 = 10;
        d     = 1;
        while (pow10 <= lim) begin
            pow10 = pow10 * 10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/producto_bcd_conv.sv
// Sequential shift-add-3 converter turning the multiplier's binary product into packed BCD
// plus a significant-digit count for the display.
module producto_bcd_conv
    import producto_bcd_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int PW     = 2 * DW,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PW-1:0]                product,
    output logic                         busy,
    output logic                         done,
    output logic [4*DIGITS-1:0]          bcd,
    output logic [$clog2(DIGITS+1)-1:0]  sig_digits
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(PW);
    localparam int GW = $clog2(DIGITS + 1);

    if (DIGITS < min_digits(PW)) begin : g_digits_check
        $error("producto_bcd_conv: DIGITS too small for PW-bit input");
    end

    conv_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [PW-1:0] bin_sh_reg;
    logic [SW-1:0] scratch_reg;
    logic [SW-1:0] adj;
    logic [SW-1:0] bcd_reg;
    logic [GW-1:0] sig_reg;
    logic [GW-1:0] sig_next;
    logic          done_reg;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch_reg[4*gi +: 4]),
            .adjusted (adj[4*gi +: 4])
        );
    end

    // Highest nonzero digit position + 1; an all-zero result still reports one digit.
    always_comb begin
        sig_next = GW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_reg[4*i +: 4] != 4'd0) begin
                sig_next = GW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bin_sh_reg  <= '0;
            scratch_reg <= '0;
            bcd_reg     <= '0;
            sig_reg     <= GW'(1);
            done_reg    <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_sh_reg  <= product;
                        scratch_reg <= '0;
                        cnt_reg     <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Correction feeds the shift in the same cycle, so digits never leave 0..9.
                    scratch_reg <= {adj[SW-2:0], bin_sh_reg[PW-1]};
                    bin_sh_reg  <= {bin_sh_reg[PW-2:0], 1'b0};
                    cnt_reg     <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(PW - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bcd_reg   <= scratch_reg;
                    sig_reg   <= sig_next;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign bcd        = bcd_reg;
    assign sig_digits = sig_reg;

endmodule

// File: tb/tb_producto_bcd_conv.sv
// Scoreboard bench for producto_bcd_conv: stimulus pushes expected results, a monitor checks each done.
module tb_producto_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [2:0]  sig_digits;

    typedef struct {
        logic [19:0] bcd;
        logic [2:0]  sig;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          applied    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    logic [19:0] bcd_hold   = '0;

    producto_bcd_conv dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .product    (product),
        .busy       (busy),
        .done       (done),
        .bcd        (bcd),
        .sig_digits (sig_digits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        applied = applied + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pops one expectation per done pulse; outputs must hold steady between pulses.
    always @(negedge clk) begin
        if (!rst) begin
            bcd_hold = '0;
        end else begin
            for (int d = 0; d < 5; d++) begin
                if (dut.scratch_reg[4*d +: 4] > 4'd9) begin
                    miscompares = miscompares + 1;
                    $display("FAIL scratch_digit%0d: got %0h, expected <= 9", d, dut.scratch_reg[4*d +: 4]);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    applied     = applied + 1;
                    miscompares = miscompares + 1;
                    $display("FAIL unexpected_done: got done=1 bcd=%05h, expected no pulse", bcd);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd", 32'(bcd), 32'(e.bcd));
                    check("sig_digits", 32'(sig_digits), 32'(e.sig));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
                bcd_hold = bcd;
            end else if (bcd !== bcd_hold) begin
                miscompares = miscompares + 1;
                $display("FAIL bcd_stable: got %05h, expected %05h", bcd, bcd_hold);
            end
        end
    end

    // Waits for the converter to be free, then issues one start pulse.
    task automatic issue(input logic [15:0] p, input logic [19:0] eb, input logic [2:0] es);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (busy) begin
            applied     = applied + 1;
            miscompares = miscompares + 1;
            $display("FAIL idle_timeout: got busy=1, expected busy=0 within 100 cycles");
        end
        start   = 1'b1;
        product = p;
        exp_q.push_back('{eb, es, cyc + 18});
        $display("issue product=%0d expect bcd=%05h sig=%0d", p, eb, es);
        @(negedge clk);
        start   = 1'b0;
        product = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (exp_q.size() != 0) begin
            applied     = applied + 1;
            miscompares = miscompares + 1;
            $display("FAIL done_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        start   = 1'b0;
        product = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_sig", 32'(sig_digits), 32'd1);
        #2 rst = 1'b1;

        issue(16'h0000, 20'h00000, 3'd1);
        drain();

        issue(16'd10795, 20'h10795, 3'd5);
        n = 0;
        while (busy && n < 100) begin
            n = n + 1;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd17);
        drain();

        issue(16'd7225, 20'h07225, 3'd4);
        issue(16'hFFFF, 20'h65535, 3'd5);
        drain();

        // Start while busy must be ignored; the next start lands in the done cycle.
        issue(16'd1234, 20'h01234, 3'd4);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        product = 16'd9999;
        @(negedge clk);
        start   = 1'b0;
        issue(16'd300, 20'h00300, 3'd3);
        drain();

        // Abort mid-conversion: no done pulse, outputs back to reset values at once.
        issue(16'd4660, 20'h04660, 3'd4);
        repeat (7) @(negedge clk);
        exp_q.delete();
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_sig", 32'(sig_digits), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        issue(16'd42, 20'h00042, 3'd2);
        issue(16'd10000, 20'h10000, 3'd5);
        issue(16'd9, 20'h00009, 3'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
